// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the instruction controller.
//   opcode_e  - 4-bit opcode map (B-F unused, executed as NOOP)
//   state_e   - controller FSM states
//   ALU_*     - ALU function select codes driven on ALU_Sel
//   *_MSB/LSB - instruction-register field positions
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_XOR   = 4'h6,
    OP_OR    = 4'h7,
    OP_AND   = 4'h8,
    OP_INC   = 4'h9,
    OP_PASS  = 4'hA
  } opcode_e;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_NOOP, S_LOAD_A, S_LOAD_B, S_STORE, S_ALU, S_HALT
  } state_e;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int ADDR_MSB = 11;  // LOAD/STORE data address
  localparam int ADDR_LSB = 4;
  localparam int RA_MSB   = 11;  // ALU ops
  localparam int RA_LSB   = 8;
  localparam int RB_MSB   = 7;
  localparam int RB_LSB   = 4;
  localparam int RD_MSB   = 3;   // ALU dest / LOAD-STORE register
  localparam int RD_LSB   = 0;

  // ALU function select for an opcode; ALU_ZERO for anything that is not an ALU op.
  function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel_of = ALU_ADD;
      OP_SUB:  alu_sel_of = ALU_SUB;
      OP_XOR:  alu_sel_of = ALU_XOR;
      OP_OR:   alu_sel_of = ALU_OR;
      OP_AND:  alu_sel_of = ALU_AND;
      OP_INC:  alu_sel_of = ALU_INC;
      OP_PASS: alu_sel_of = ALU_PASS;
      default: alu_sel_of = ALU_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/instr_controller_if.sv
// instr_controller_if: instruction-memory / datapath control bundle.
//   master - controller side: reads IR_In, drives every control line
//   slave  - datapath side: supplies IR_In, consumes the control lines
interface instr_controller_if #(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
);
  logic [15:0]        IR_In;
  logic [PC_W-1:0]    PC_Addr;
  logic [DADDR_W-1:0] D_Addr;
  logic               D_Wr;
  logic               RF_s;
  logic [RADDR_W-1:0] RF_W_Addr;
  logic               RF_W_en;
  logic [RADDR_W-1:0] RF_Ra_Addr;
  logic [RADDR_W-1:0] RF_Rb_Addr;
  logic [2:0]         ALU_Sel;
  logic               Halted;

  modport master (
    input  IR_In,
    output PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, Halted
  );

  modport slave (
    output IR_In,
    input  PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, Halted
  );
endinterface

// File: rtl/pc_counter.sv
// pc_counter: program counter with synchronous clear/increment.
//   clk, rst_n - clock, asynchronous active-low reset (pc -> 0)
//   clr        - synchronous clear (wins over inc)
//   inc        - synchronous increment, wraps 2^PC_W-1 -> 0
//   pc         - current count
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pc <= '0;
    else if (clr) pc <= '0;
    else if (inc) pc <= pc + PC_W'(1);  // natural wrap at full width
  end

endmodule

// File: rtl/instr_controller.sv
// instr_controller: fetch/decode/execute control unit for the 16-bit datapath.
//   Clk, ResetN - clock, asynchronous active-low reset (all outputs 0 in reset)
//   bus         - master side of instr_controller_if: IR_In in, PC/data-memory/
//                 register-file/ALU control lines and Halted out
// Control outputs are registered: each state's outputs are loaded on the edge
// that enters the state, so they depend only on state and IR.
module instr_controller
  import ctrl_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input logic                Clk,
  input logic                ResetN,
  instr_controller_if.master bus
);

  state_e             state;
  logic [15:0]        ir;
  logic [3:0]         op;
  logic [PC_W-1:0]    pc;
  logic               pc_clr;
  logic               pc_inc;

  logic [DADDR_W-1:0] d_addr;
  logic               d_wr;
  logic               rf_s;
  logic [RADDR_W-1:0] rf_w_addr;
  logic               rf_w_en;
  logic [RADDR_W-1:0] rf_ra_addr;
  logic [RADDR_W-1:0] rf_rb_addr;
  logic [2:0]         alu_sel;
  logic               halted;

  assign op     = ir[OP_MSB:OP_LSB];
  assign pc_clr = (state == S_INIT);
  assign pc_inc = (state == S_FETCH);

  pc_counter #(.PC_W(PC_W)) u_pc (
    .clk   (Clk),
    .rst_n (ResetN),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // IR only changes on FETCH -> DECODE and DECODE drives nothing, so the
  // decode of `ir` below is always of the instruction being executed.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= S_INIT;
      ir         <= '0;
      d_addr     <= '0;
      d_wr       <= 1'b0;
      rf_s       <= 1'b0;
      rf_w_addr  <= '0;
      rf_w_en    <= 1'b0;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      alu_sel    <= ALU_ZERO;
      halted     <= 1'b0;
    end else begin
      d_addr     <= '0;
      d_wr       <= 1'b0;
      rf_s       <= 1'b0;
      rf_w_addr  <= '0;
      rf_w_en    <= 1'b0;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      alu_sel    <= ALU_ZERO;
      halted     <= 1'b0;
      case (state)
        S_INIT:  state <= S_FETCH;
        S_FETCH: begin
          ir    <= bus.IR_In;
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_LOAD: begin
              state  <= S_LOAD_A;
              d_addr <= DADDR_W'(ir[ADDR_MSB:ADDR_LSB]);
              rf_s   <= 1'b1;
            end
            OP_STORE: begin
              state      <= S_STORE;
              d_addr     <= DADDR_W'(ir[ADDR_MSB:ADDR_LSB]);
              rf_ra_addr <= RADDR_W'(ir[RD_MSB:RD_LSB]);
              d_wr       <= 1'b1;
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_INC, OP_PASS: begin
              state      <= S_ALU;
              rf_ra_addr <= RADDR_W'(ir[RA_MSB:RA_LSB]);
              rf_rb_addr <= RADDR_W'(ir[RB_MSB:RB_LSB]);
              rf_w_addr  <= RADDR_W'(ir[RD_MSB:RD_LSB]);
              alu_sel    <= alu_sel_of(op);
              rf_w_en    <= 1'b1;
            end
            default: state <= S_NOOP;  // NOOP and the unused opcodes B-F
          endcase
        end
        // LOAD_A covers the data-memory read latency; the write happens in LOAD_B.
        S_LOAD_A: begin
          state     <= S_LOAD_B;
          d_addr    <= DADDR_W'(ir[ADDR_MSB:ADDR_LSB]);
          rf_s      <= 1'b1;
          rf_w_addr <= RADDR_W'(ir[RD_MSB:RD_LSB]);
          rf_w_en   <= 1'b1;
        end
        S_HALT: halted <= 1'b1;  // sticky until reset
        default: state <= S_FETCH;  // NOOP, LOAD_B, STORE, ALU
      endcase
    end
  end

  assign bus.PC_Addr    = pc;
  assign bus.D_Addr     = d_addr;
  assign bus.D_Wr       = d_wr;
  assign bus.RF_s       = rf_s;
  assign bus.RF_W_Addr  = rf_w_addr;
  assign bus.RF_W_en    = rf_w_en;
  assign bus.RF_Ra_Addr = rf_ra_addr;
  assign bus.RF_Rb_Addr = rf_rb_addr;
  assign bus.ALU_Sel    = alu_sel;
  assign bus.Halted     = halted;

endmodule

// File: tb/tb_instr_controller.sv
// tb_instr_controller: drives instr_controller from a behavioural instruction
// memory and compares every cycle's outputs with a per-instruction trace model.
module tb_instr_controller;

  localparam int PC_W    = 7;
  localparam int DADDR_W = 8;
  localparam int RADDR_W = 4;

  typedef struct packed {
    logic [6:0] pc;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] wa;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
  } obs_t;

  logic        Clk;
  logic        ResetN;
  logic [15:0] imem [0:127];
  logic [6:0]  mpc;
  int          n_assert;
  int          n_fail;

  instr_controller_if #(.PC_W(PC_W), .DADDR_W(DADDR_W), .RADDR_W(RADDR_W)) bus ();
  assign bus.IR_In = imem[bus.PC_Addr];

  instr_controller #(.PC_W(PC_W), .DADDR_W(DADDR_W), .RADDR_W(RADDR_W)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ALU select table straight from the opcode map.
  function automatic logic [2:0] ref_alu(input logic [3:0] op);
    logic [2:0] t [0:15];
    t = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd4, 3'd5,
          3'd6, 3'd7, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    return t[op];
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc     = bus.PC_Addr;
    o.d_addr = bus.D_Addr;
    o.d_wr   = bus.D_Wr;
    o.rf_s   = bus.RF_s;
    o.wa     = bus.RF_W_Addr;
    o.w_en   = bus.RF_W_en;
    o.ra     = bus.RF_Ra_Addr;
    o.rb     = bus.RF_Rb_Addr;
    o.alu    = bus.ALU_Sel;
    o.halted = bus.Halted;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t e);
    obs_t o;
    o = sample();
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  // Expected cycle trace for one instruction, starting in FETCH.
  // HALT checks n_halt cycles of the halted state and does not return to fetch.
  task automatic exec_instr(input logic [15:0] w, input int n_halt);
    obs_t e;
    logic [3:0] op;
    op = w[15:12];
    e = '0;
    e.pc = mpc;
    chk("fetch", e);
    step();
    mpc = mpc + 7'd1;
    e.pc = mpc;
    chk("decode", e);
    step();
    if (op == 4'h2) begin
      e.d_addr = w[11:4];
      e.rf_s   = 1'b1;
      chk("load_a", e);
      step();
      e.wa   = w[3:0];
      e.w_en = 1'b1;
      chk("load_b", e);
      step();
    end else if (op == 4'h1) begin
      e.d_addr = w[11:4];
      e.ra     = w[3:0];
      e.d_wr   = 1'b1;
      chk("store", e);
      step();
    end else if (op == 4'h5) begin
      e.halted = 1'b1;
      for (int i = 0; i < n_halt; i++) begin
        chk("halt", e);
        step();
      end
    end else if (op >= 4'h3 && op <= 4'hA) begin
      e.ra   = w[11:8];
      e.rb   = w[7:4];
      e.wa   = w[3:0];
      e.alu  = ref_alu(op);
      e.w_en = 1'b1;
      chk("alu", e);
      step();
    end else begin
      chk("noop", e);
      step();
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    do op = 4'($urandom_range(0, 15)); while (op == 4'h5);
    return {op, 12'($urandom)};
  endfunction

  initial begin
    obs_t z;
    logic [15:0] w;
    logic [3:0] sweep [0:6];
    int a;
    n_assert = 0;
    n_fail   = 0;
    z = '0;
    sweep = '{4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;

    // Program: directed LOAD/STORE, ALU sweep, illegal opcodes, random mix,
    // and a final LOAD that gets interrupted by reset.
    a = 0;
    imem[a++] = 16'h21B5;
    imem[a++] = 16'h1A03;
    for (int i = 0; i < 7; i++) imem[a++] = {sweep[i], 12'h127};
    for (int i = 11; i < 16; i++) imem[a++] = {4'(i), 12'($urandom)};
    for (int i = 0; i < 40; i++) imem[a++] = rand_instr();
    imem[a] = 16'h2C4E;

    ResetN = 1'b0;
    step();
    step();
    chk("reset", z);
    ResetN = 1'b1;           // released at negedge, taken on next rising edge
    chk("init", z);
    step();
    mpc = 7'd0;
    for (int i = 0; i < a; i++) exec_instr(imem[i], 0);

    // Interrupted LOAD: reset in LOAD_A must clear outputs without a clock edge.
    begin
      obs_t e;
      e = '0;
      e.pc = mpc;
      chk("mid_fetch", e);
      step();
      e.pc = mpc + 7'd1;
      chk("mid_decode", e);
      step();
      e.d_addr = 8'hC4;
      e.rf_s   = 1'b1;
      chk("mid_load_a", e);
      #2 ResetN = 1'b0;
      #1 chk("async_reset", z);
    end
    step();
    step();
    chk("reset_hold", z);
    ResetN = 1'b1;
    chk("init2", z);
    step();
    mpc = 7'd0;

    // 128 NOOP-class instructions (opcode 0 or B-F): PC walks the whole space.
    for (int i = 0; i < 128; i++) begin
      w = {4'($urandom_range(0, 5)), 12'($urandom)};
      if (w[15:12] != 4'h0) w[15:12] = w[15:12] + 4'hA;  // 1..5 -> B..F
      imem[i] = w;
    end
    for (int i = 0; i < 128; i++) exec_instr(imem[i], 0);
    begin
      obs_t o;
      o = sample();
      n_assert++;
      assert (o.pc === 7'd0) else begin
        n_fail++;
        $error("FAIL wrap: observed pc %0d expected 0", o.pc);
      end
    end

    // Illegal opcode then HALT held for 20 cycles with PC frozen.
    imem[0] = 16'hF123;
    imem[1] = 16'h5000;
    exec_instr(imem[0], 0);
    exec_instr(imem[1], 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
